// File: rtl/ofdm_symbol_sched.sv
// rtl/ofdm_symbol_sched.sv - OFDM symbol scheduler: bit packing, IFFT trigger, CP+body readout.
module ofdm_symbol_sched #(
    parameter int NSC    = 8,
    parameter int BPS    = 4,
    parameter int CP_LEN = 2,
    parameter int SYMS   = 4,
    parameter int ADDR_W = $clog2(NSC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              map_we,
    output logic [ADDR_W-1:0] map_addr,
    output logic [BPS-1:0]    map_data,
    output logic              ifft_start,
    input  logic              ifft_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              cp_flag,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy
);

    localparam int BIT_W = (BPS > 1) ? $clog2(BPS) : 1;
    localparam int SYM_W = (SYMS > 1) ? $clog2(SYMS) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(BPS - 1);
    localparam logic [ADDR_W-1:0] SC_LAST  = ADDR_W'(NSC - 1);
    localparam logic [ADDR_W-1:0] CP_LAST  = ADDR_W'(CP_LEN - 1);
    localparam logic [ADDR_W-1:0] CP_BASE  = ADDR_W'(NSC - CP_LEN);
    localparam logic [SYM_W-1:0]  SYM_LAST = SYM_W'(SYMS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        FLUSH = 3'd2,
        XFORM = 3'd3,
        CP    = 3'd4,
        BODY  = 3'd5
    } state_t;

    state_t             state, state_nx;
    logic [BIT_W-1:0]   bit_cnt;
    logic [ADDR_W-1:0]  sc_cnt;
    logic [ADDR_W-1:0]  rd_cnt;
    logic [SYM_W-1:0]   sym_cnt;
    logic [BPS-1:0]     word;
    logic [BPS-1:0]     word_nx;
    logic               take;
    logic               word_full;

    assign take      = (state == FILL) && bit_valid;
    assign word_full = take && (bit_cnt == BIT_LAST);

    always_comb begin
        word_nx          = word;
        word_nx[bit_cnt] = bit_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus outputs that are pure decodes of the state/counter registers.
    always_comb begin
        state_nx  = state;
        bit_ready = 1'b0;
        busy      = 1'b1;
        rd_en     = 1'b0;
        cp_flag   = 1'b0;
        rd_addr   = '0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable) state_nx = FILL;
            end
            FILL: begin
                bit_ready = 1'b1;
                if (word_full && (sc_cnt == SC_LAST)) state_nx = FLUSH;
            end
            FLUSH: state_nx = XFORM;
            XFORM: begin
                // The trigger cycle itself cannot complete the transform.
                if (ifft_done && !ifft_start) state_nx = CP;
            end
            CP: begin
                rd_en   = 1'b1;
                cp_flag = 1'b1;
                rd_addr = CP_BASE + rd_cnt;
                if (rd_cnt == CP_LAST) state_nx = BODY;
            end
            BODY: begin
                rd_en   = 1'b1;
                rd_addr = rd_cnt;
                if (rd_cnt == SC_LAST) begin
                    if (sym_cnt == SYM_LAST) begin
                        frame_end = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        state_nx  = FILL;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            sc_cnt      <= '0;
            rd_cnt      <= '0;
            sym_cnt     <= '0;
            word        <= '0;
            map_we      <= 1'b0;
            map_addr    <= '0;
            map_data    <= '0;
            ifft_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            map_we      <= 1'b0;
            ifft_start  <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    sc_cnt  <= '0;
                    rd_cnt  <= '0;
                    sym_cnt <= '0;
                    if (enable) frame_start <= 1'b1;
                end
                FILL: begin
                    if (take) begin
                        word <= word_nx;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt  <= '0;
                            sc_cnt   <= sc_cnt + 1'b1;
                            map_we   <= 1'b1;
                            map_addr <= sc_cnt;
                            map_data <= word_nx;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: ifft_start <= 1'b1;
                XFORM: rd_cnt <= '0;
                CP: rd_cnt <= (rd_cnt == CP_LAST) ? '0 : rd_cnt + 1'b1;
                BODY: begin
                    // NSC is a power of two, so the body index wraps back to 0 by itself.
                    rd_cnt <= rd_cnt + 1'b1;
                    if ((rd_cnt == SC_LAST) && (sym_cnt != SYM_LAST)) sym_cnt <= sym_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_sched.sv
// tb/tb_ofdm_symbol_sched.sv - directed self-checking bench for ofdm_symbol_sched.
module tb_ofdm_symbol_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       ifft_done = 1'b0;
    logic       bit_ready;
    logic       map_we;
    logic [2:0] map_addr;
    logic [3:0] map_data;
    logic       ifft_start;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic       cp_flag;
    logic       frame_start;
    logic       frame_end;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] pat = 4'b0110;

    ofdm_symbol_sched dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bit_valid(bit_valid),
        .bit_in(bit_in),
        .bit_ready(bit_ready),
        .map_we(map_we),
        .map_addr(map_addr),
        .map_data(map_data),
        .ifft_start(ifft_start),
        .ifft_done(ifft_done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .cp_flag(cp_flag),
        .frame_start(frame_start),
        .frame_end(frame_end),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [17:0] snap;
        #1 reset = 1'b1;
        #1;
        snap = {bit_ready, map_we, map_addr, map_data, ifft_start, rd_en, rd_addr,
                cp_flag, frame_start, frame_end, busy};
        checks++;
        if (snap !== 18'd0) begin
            errors++;
            $display("FAIL reset_async: outputs=%b required all zero", snap);
        end
        tick;
        tick;
        snap = {bit_ready, map_we, map_addr, map_data, ifft_start, rd_en, rd_addr,
                cp_flag, frame_start, frame_end, busy};
        checks++;
        if (snap !== 18'd0) begin
            errors++;
            $display("FAIL reset_held: outputs=%b required all zero", snap);
        end
        reset = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b bit_ready=%b required 0 0", busy, bit_ready);
        end
    endtask

    // Enters at the first FILL cycle; leaves at the ifft_start cycle.
    task automatic do_fill(input bit toggle, input bit spur, input bit hold, input int exp_cycles);
        int nb = 0;
        int we = 0;
        int cyc = 0;
        int fc = 0;
        bit acc;
        bit v;
        v = !toggle;
        while (nb < 32 && cyc < 300) begin
            bit_valid = v;
            bit_in    = pat[nb % 4];
            ifft_done = spur && (cyc % 3 == 0);
            if (bit_ready === 1'b1) fc++;
            acc = v && (bit_ready === 1'b1);
            tick;
            cyc++;
            if (acc) nb++;
            if (map_we === 1'b1) begin
                checks++;
                if (map_addr !== 3'(we) || map_data !== 4'b0110) begin
                    errors++;
                    $display("FAIL map_write: addr=%0d data=%b required addr=%0d data=0110",
                             map_addr, map_data, we);
                end
                we++;
            end
            checks++;
            if (frame_start !== 1'b0) begin
                errors++;
                $display("FAIL frame_start_extra: frame_start=%b required 0", frame_start);
            end
            if (toggle) v = !v;
        end
        checks++;
        if (nb != 32) begin
            errors++;
            $display("FAIL fill_timeout: bits accepted=%0d required 32", nb);
        end
        checks++;
        if (fc != exp_cycles) begin
            errors++;
            $display("FAIL fill_cycles: cycles=%0d required %0d", fc, exp_cycles);
        end
        checks++;
        if (we != 8) begin
            errors++;
            $display("FAIL map_we_count: writes=%0d required 8", we);
        end
        bit_valid = hold;
        ifft_done = spur;
        checks++;
        if (bit_ready !== 1'b0 || ifft_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: bit_ready=%b ifft_start=%b busy=%b required 0 0 1",
                     bit_ready, ifft_start, busy);
        end
        tick;
        checks++;
        if (ifft_start !== 1'b1 || map_we !== 1'b0 || bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL ifft_start_timing: ifft_start=%b map_we=%b bit_ready=%b required 1 0 0",
                     ifft_start, map_we, bit_ready);
        end
    endtask

    // Enters at the ifft_start cycle; ifft_done returns 5 cycles later.
    task automatic do_readout(input bit coinc, input bit last);
        logic [7:0] act;
        logic [7:0] exp_v;
        int         a;
        ifft_done = coinc;
        tick;
        ifft_done = 1'b0;
        repeat (4) begin
            checks++;
            if (rd_en !== 1'b0 || ifft_start !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL xform_wait: rd_en=%b ifft_start=%b busy=%b required 0 0 1",
                         rd_en, ifft_start, busy);
            end
            tick;
        end
        checks++;
        if (rd_en !== 1'b0) begin
            errors++;
            $display("FAIL xform_early_read: rd_en=%b required 0", rd_en);
        end
        ifft_done = 1'b1;
        tick;
        ifft_done = 1'b0;
        for (int j = 0; j < 10; j++) begin
            a     = (j < 2) ? 6 + j : j - 2;
            exp_v = {1'b1, (j < 2), 3'(a), (last && j == 9), 1'b0, 1'b0};
            act   = {rd_en, cp_flag, rd_addr, frame_end, map_we, bit_ready};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL readout[%0d]: rd_en,cp,addr,fe,we,rdy=%b required %b", j, act, exp_v);
            end
            tick;
        end
        checks++;
        if (rd_en !== 1'b0 || frame_end !== 1'b0 || bit_ready !== !last || busy !== !last) begin
            errors++;
            $display("FAIL after_readout: rd_en=%b fe=%b bit_ready=%b busy=%b required 0 0 %b %b",
                     rd_en, frame_end, bit_ready, busy, !last, !last);
        end
    endtask

    task automatic test_single_symbol;
        checks++;
        if (bit_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_enable: bit_ready=%b busy=%b required 0 0", bit_ready, busy);
        end
        enable = 1'b1;
        tick;
        enable = 1'b0;
        checks++;
        if (frame_start !== 1'b1 || bit_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_begin: frame_start=%b bit_ready=%b busy=%b required 1 1 1",
                     frame_start, bit_ready, busy);
        end
        do_fill(1'b0, 1'b0, 1'b0, 32);
    endtask

    task automatic test_readout;
        do_readout(1'b0, 1'b0);
    endtask

    task automatic test_stalls;
        do_fill(1'b1, 1'b0, 1'b0, 64);
        do_readout(1'b0, 1'b0);
    endtask

    task automatic test_spurious;
        do_fill(1'b0, 1'b1, 1'b1, 32);
        do_readout(1'b1, 1'b0);
        do_fill(1'b0, 1'b0, 1'b0, 32);
        do_readout(1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        logic [17:0] snap;
        enable = 1'b1;
        tick;
        enable = 1'b0;
        do_fill(1'b0, 1'b0, 1'b0, 32);
        tick;
        ifft_done = 1'b1;
        tick;
        ifft_done = 1'b0;
        repeat (4) tick;
        checks++;
        if (rd_en !== 1'b1 || cp_flag !== 1'b0) begin
            errors++;
            $display("FAIL mid_body_reach: rd_en=%b cp_flag=%b required 1 0", rd_en, cp_flag);
        end
        #2 reset = 1'b1;
        #1;
        snap = {bit_ready, map_we, map_addr, map_data, ifft_start, rd_en, rd_addr,
                cp_flag, frame_start, frame_end, busy};
        checks++;
        if (snap !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid_body: outputs=%b required all zero", snap);
        end
        reset = 1'b0;
        repeat (5) begin
            tick;
            checks++;
            if (rd_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: rd_en=%b busy=%b required 0 0", rd_en, busy);
            end
        end
    endtask

    task automatic test_full_frame;
        int nb = 0;
        int since = 100;
        int fs = 0;
        int ifs = 0;
        int rds = 0;
        int fes = 0;
        int idles = 0;
        int cyc = 0;
        bit done2 = 1'b0;
        enable    = 1'b1;
        bit_valid = 1'b1;
        while (!done2 && cyc < 2000) begin
            bit_in    = pat[nb % 4];
            ifft_done = (since == 2);
            if (bit_ready === 1'b1) nb++;
            tick;
            cyc++;
            if (frame_start === 1'b1) fs++;
            if (fs >= 2) begin
                done2 = 1'b1;
            end else begin
                if (ifft_start === 1'b1) ifs++;
                if (rd_en === 1'b1) rds++;
                if (frame_end === 1'b1) fes++;
                if (busy === 1'b0) idles++;
            end
            if (ifft_start === 1'b1) since = 0;
            else since++;
        end
        enable    = 1'b0;
        bit_valid = 1'b0;
        ifft_done = 1'b0;
        checks++;
        if (!done2) begin
            errors++;
            $display("FAIL frame_timeout: frame_start pulses=%0d required 2", fs);
        end
        checks++;
        if (ifs != 4 || rds != 40 || fes != 1) begin
            errors++;
            $display("FAIL frame_counts: ifft_start=%0d rd_en=%0d frame_end=%0d required 4 40 1",
                     ifs, rds, fes);
        end
        checks++;
        if (idles != 1) begin
            errors++;
            $display("FAIL frame_gap: idle cycles=%0d required 1", idles);
        end
    endtask

    initial begin
        test_reset;
        test_single_symbol;
        test_readout;
        test_stalls;
        test_spurious;
        test_reset_mid;
        test_full_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
